imm_ext_pipe: RTL and testbench

Parametrised, pipelined immediate extender for the decode/execute boundary of the pipelined CPU. It widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: zero, sign, load-upper or branch-offset. Results are registered behind a valid/ready handshake with a two-entry skid buffer, so downstream stalls never lose or reorder operands. A synchronous flush discards in-flight entries on branch mispredict or exception.

---
 rtl/imm_ext_pipe.sv | 105 ++++++++++
 tb/tb_imm_ext_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate extender for the decode/execute boundary: widens an IN_W-bit immediate
// (zero / sign / load-upper / branch) into a two-entry registered valid/ready pipeline.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst_N,
  input  logic [IN_W-1:0]  Imme_In,
  input  logic [1:0]       Ext_Mode,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [OUT_W-1:0] Ext_Out,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  input  logic             Flush,
  output logic [1:0]       Occupancy
);

  localparam int PAD_W = OUT_W - IN_W;

  // Handshake: a beat transfers on a rising edge where valid & ready are both high;
  // In_Ready depends only on stored state, never combinationally on Out_Ready.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [OUT_W-1:0]  or_data_q, or_data_d;
  logic [OUT_W-1:0]  sr_data_q, sr_data_d;
  logic [OUT_W-1:0]  sext_val;
  logic [OUT_W-1:0]  ext_val;
  logic              accept;
  logic              pop;

  always_comb begin
    sext_val = {{PAD_W{Imme_In[IN_W-1]}}, Imme_In};
    ext_val  = '0;
    case (Ext_Mode)
      2'b00:   ext_val = {{PAD_W{1'b0}}, Imme_In};
      2'b01:   ext_val = sext_val;
      2'b10:   ext_val = {Imme_In, {PAD_W{1'b0}}};
      default: ext_val = {sext_val[OUT_W-3:0], 2'b00};
    endcase
  end

  assign In_Ready  = (state_q != ST_FULL);
  assign Out_Valid = (state_q != ST_EMPTY);
  assign Ext_Out   = or_data_q;
  assign Occupancy = state_q;
  assign accept    = In_Valid & In_Ready;
  assign pop       = Out_Valid & Out_Ready;

  // OR always holds the oldest entry; SR is only ever filled when OR is occupied
  // and not draining, so FIFO order falls out of the state encoding.
  always_comb begin
    state_d   = state_q;
    or_data_d = or_data_q;
    sr_data_d = sr_data_q;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            or_data_d = ext_val;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            or_data_d = ext_val;
          end else if (accept) begin
            sr_data_d = ext_val;
            state_d   = ST_FULL;
          end else if (pop) begin
            state_d   = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            or_data_d = sr_data_q;
            state_d   = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q   <= ST_EMPTY;
      or_data_q <= '0;
      sr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      or_data_q <= or_data_d;
      sr_data_q <= sr_data_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboarded bench for imm_ext_pipe: directed mode, backpressure, flush and reset
// scenarios, a random handshake phase, and a narrow 12/24 instance.
module tb_imm_ext_pipe;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst_N;
  logic [15:0] Imme_In;
  logic [1:0]  Ext_Mode;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] Ext_Out;
  logic        Out_Valid;
  logic        Out_Ready;
  logic        Flush;
  logic [1:0]  Occupancy;

  logic [11:0] imm2;
  logic [1:0]  mode2;
  logic        in_valid2;
  logic        in_ready2;
  logic [23:0] ext_out2;
  logic        out_valid2;
  logic [1:0]  occ2;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .Clk(Clk), .Rst_N(Rst_N), .Imme_In(Imme_In), .Ext_Mode(Ext_Mode),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .Ext_Out(Ext_Out),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Flush(Flush),
    .Occupancy(Occupancy)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(24)) dut_narrow (
    .Clk(Clk), .Rst_N(Rst_N), .Imme_In(imm2), .Ext_Mode(mode2),
    .In_Valid(in_valid2), .In_Ready(in_ready2), .Ext_Out(ext_out2),
    .Out_Valid(out_valid2), .Out_Ready(1'b1), .Flush(1'b0),
    .Occupancy(occ2)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
    logic signed [31:0] s;
    s = $signed(imm);
    case (mode)
      2'd0:    return {16'h0000, imm};
      2'd1:    return s;
      2'd2:    return {imm, 16'h0000};
      default: return s * 4;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  // Inputs change just after posedge, so at negedge everything that the next
  // edge will act on is stable.
  logic        hold_valid = 1'b0;
  logic [31:0] hold_val;

  always @(negedge Clk) begin
    if (!Rst_N) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid && Out_Valid) chk("hold_stable", Ext_Out, hold_val);
      hold_valid = Out_Valid && !Out_Ready && !Flush;
      hold_val   = Ext_Out;
      if (Flush) begin
        exp_q.delete();
      end else begin
        if (Out_Valid && Out_Ready) begin
          if (exp_q.size() == 0) chk("unexpected_pop", Ext_Out, 32'hxxxx_xxxx);
          else chk("sb_pop", Ext_Out, exp_q.pop_front());
        end
        if (In_Valid && In_Ready) exp_q.push_back(model_ext(Imme_In, Ext_Mode));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    In_Valid = 1'b0;
    repeat (n) step();
  endtask

  // Holds the beat until an edge where it is accepted; returns just after that edge.
  task automatic push(input logic [15:0] d, input logic [1:0] m);
    int waited = 0;
    Imme_In  = d;
    Ext_Mode = m;
    In_Valid = 1'b1;
    while (!In_Ready && waited < 50) begin
      step();
      waited++;
    end
    if (!In_Ready) chk("push_timeout", {31'd0, In_Ready}, 32'd1);
    step();
  endtask

  task automatic drain();
    int waited = 0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    while (exp_q.size() != 0 && waited < 50) begin
      step();
      waited++;
    end
    step();
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("drain_out_valid", {31'd0, Out_Valid}, 32'd0);
  endtask

  task automatic narrow_check(input logic [11:0] d, input logic [1:0] m, input logic [23:0] expv);
    imm2      = d;
    mode2     = m;
    in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    chk("narrow_valid", {31'd0, out_valid2}, 32'd1);
    chk("narrow_val", {8'd0, ext_out2}, {8'd0, expv});
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] mode_in  [5] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h7FFF};
  logic [1:0]  mode_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
  logic [31:0] mode_exp [5] = '{32'h0000_8000, 32'hFFFF_8000, 32'h1234_0000,
                                32'hFFFF_FFFC, 32'h0001_FFFC};

  initial begin
    Rst_N = 1'b0; Imme_In = '0; Ext_Mode = '0; In_Valid = 1'b0;
    Out_Ready = 1'b0; Flush = 1'b0;
    imm2 = '0; mode2 = '0; in_valid2 = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
    chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);
    chk("rst_occ", {30'd0, Occupancy}, 32'd0);
    chk("rst_ext_out", Ext_Out, 32'd0);
    repeat (2) step();
    Rst_N = 1'b1;
    step();

    // extension modes, one-cycle latency
    Out_Ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(mode_in[i], mode_sel[i]);
      In_Valid = 1'b0;
      chk("mode_out_valid", {31'd0, Out_Valid}, 32'd1);
      chk("mode_value", Ext_Out, mode_exp[i]);
      idle(1);
    end

    // backpressure: only two absorbed
    Out_Ready = 1'b0;
    push(16'h0001, 2'd0);
    push(16'h0002, 2'd0);
    Imme_In = 16'h0003; In_Valid = 1'b1;
    chk("bp_in_ready", {31'd0, In_Ready}, 32'd0);
    chk("bp_occ", {30'd0, Occupancy}, 32'd2);
    chk("bp_head", Ext_Out, 32'h1);
    repeat (3) step();
    chk("bp_occ_stall", {30'd0, Occupancy}, 32'd2);
    chk("bp_head_stall", Ext_Out, 32'h1);
    Out_Ready = 1'b1;
    step();
    chk("bp_ready_after_pop_edge", {31'd0, In_Ready}, 32'd1);
    push(16'h0003, 2'd0);
    drain();

    // simultaneous accept + pop keeps occupancy at one
    Out_Ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(16'h0100 + 16'(i), 2'd0);
      chk("ap_occ", {30'd0, Occupancy}, 32'd1);
      chk("ap_value", Ext_Out, 32'h0100 + 32'(i));
    end
    drain();

    // flush in FULL with an offered beat
    Out_Ready = 1'b0;
    push(16'h0011, 2'd0);
    push(16'h0022, 2'd0);
    Imme_In = 16'hAAAA; Ext_Mode = 2'd0; In_Valid = 1'b1; Flush = 1'b1;
    step();
    Flush = 1'b0; In_Valid = 1'b0;
    chk("flush_full_valid", {31'd0, Out_Valid}, 32'd0);
    chk("flush_full_occ", {30'd0, Occupancy}, 32'd0);
    chk("flush_full_ready", {31'd0, In_Ready}, 32'd1);

    // flush in ONE beats a simultaneous accept and pop
    Out_Ready = 1'b1;
    push(16'h0033, 2'd0);
    Imme_In = 16'hBBBB; In_Valid = 1'b1; Flush = 1'b1;
    step();
    Flush = 1'b0; In_Valid = 1'b0;
    chk("flush_one_occ", {30'd0, Occupancy}, 32'd0);
    repeat (3) step();
    chk("flush_no_leak", {31'd0, Out_Valid}, 32'd0);

    // asynchronous reset while FULL
    Out_Ready = 1'b0;
    push(16'h0044, 2'd0);
    push(16'h0055, 2'd0);
    In_Valid = 1'b0;
    #2;
    Rst_N = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", {31'd0, Out_Valid}, 32'd0);
    chk("arst_ext_out", Ext_Out, 32'd0);
    chk("arst_occ", {30'd0, Occupancy}, 32'd0);
    chk("arst_in_ready", {31'd0, In_Ready}, 32'd1);
    step();
    Rst_N = 1'b1;
    step();
    Out_Ready = 1'b1;
    push(16'hF00D, 2'd1);
    In_Valid = 1'b0;
    chk("post_rst_valid", {31'd0, Out_Valid}, 32'd1);
    chk("post_rst_value", Ext_Out, 32'hFFFF_F00D);
    drain();

    // random handshake traffic
    for (int i = 0; i < 400; i++) begin
      Imme_In   = 16'($urandom_range(0, 16'hFFFF));
      Ext_Mode  = 2'($urandom_range(0, 3));
      In_Valid  = ($urandom_range(0, 3) != 0);
      Out_Ready = ($urandom_range(0, 2) != 0);
      Flush     = ($urandom_range(0, 40) == 0);
      step();
    end
    Flush = 1'b0;
    drain();

    // narrow instance
    narrow_check(12'h800, 2'd1, 24'hFFF800);
    narrow_check(12'hABC, 2'd2, 24'hABC000);
    narrow_check(12'h800, 2'd3, 24'hFFE000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
